// File: rtl/ps_int_pkg.sv
// Shared definitions for the program-sequencer interrupt controller.
package ps_int_pkg;

    // Controller state encoding (2 bits).
    typedef enum logic [1:0] {
        IDLE_ST    = 2'd0,
        REQ_ST     = 2'd1,
        SERVICE_ST = 2'd2
    } int_state_e;

    // Default service-routine entry address.
    localparam logic [15:0] INT_VECTOR_DEFAULT = 16'h0004;

endpackage : ps_int_pkg

// File: rtl/int_edge_detect.sv
// Rising-edge detector for a clk-synchronous request line.
// A level held high for many cycles yields a single rise.
module int_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic rise
);

    logic int_d_q;

    // Delayed copy of the request line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            int_d_q <= 1'b0;
        end else begin
            int_d_q <= in;
        end
    end

    // Rise is high for the cycle in which the line first reads high.
    always_comb begin
        rise = in & ~int_d_q;
    end

endmodule : int_edge_detect

// File: rtl/ps_interrupt_ctrl.sv
// Single-level interrupt controller for the program sequencer.
// Latches one pending request, asks the sequencer to branch to the vector,
// saves the return address on acknowledge and blocks nesting until RTI.
module ps_interrupt_ctrl
    import ps_int_pkg::*;
#(
    parameter int                  PMA_SIZE   = 16,
    parameter logic [PMA_SIZE-1:0] INT_VECTOR = INT_VECTOR_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                interrupt,
    input  logic                ps_idle,
    input  logic                ps_int_en,
    input  logic [PMA_SIZE-1:0] ps_pc,
    input  logic                ps_int_ack,
    input  logic                ps_rti,
    output logic                int_req,
    output logic [PMA_SIZE-1:0] int_vector,
    output logic [PMA_SIZE-1:0] int_ret_addr,
    output logic                int_wake,
    output logic                int_busy,
    output logic                int_lost
);

    int_state_e          state_q, state_d;
    logic                pending_q, pending_d;
    logic                lost_q, lost_d;
    logic [PMA_SIZE-1:0] ret_q, ret_d;
    logic                rise;
    logic                accept;

    int_edge_detect u_edge (
        .clk   (clk),
        .reset (reset),
        .in    (interrupt),
        .rise  (rise)
    );

    // State, pending flag, sticky loss flag and saved return address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE_ST;
            pending_q <= 1'b0;
            lost_q    <= 1'b0;
            ret_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            lost_q    <= lost_d;
            ret_q     <= ret_d;
        end
    end

    // Next-state and Moore outputs; outputs depend only on state so reset clears them at once.
    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        int_req  = 1'b0;
        int_busy = 1'b0;
        accept   = 1'b0;
        case (state_q)
            IDLE_ST: begin
                if (pending_q && ps_int_en) begin
                    state_d = REQ_ST;
                end
            end
            REQ_ST: begin
                int_req = 1'b1;
                if (ps_int_ack) begin
                    accept  = 1'b1;
                    ret_d   = ps_pc;
                    state_d = SERVICE_ST;
                end else if (!ps_int_en) begin
                    state_d = IDLE_ST;
                end
            end
            SERVICE_ST: begin
                int_busy = 1'b1;
                if (ps_rti) begin
                    state_d = IDLE_ST;
                end
            end
            default: begin
                state_d = IDLE_ST;
            end
        endcase
    end

    // A rise coinciding with acceptance replaces the consumed request rather than being lost.
    always_comb begin
        pending_d = rise | (pending_q & ~accept);
        lost_d    = lost_q | (rise & pending_q & ~accept);
    end

    // Output wiring.
    always_comb begin
        int_wake     = int_req & ps_idle;
        int_vector   = INT_VECTOR;
        int_ret_addr = ret_q;
        int_lost     = lost_q;
    end

endmodule : ps_interrupt_ctrl

// File: tb/tb_ps_interrupt_ctrl.sv
// Self-checking bench for ps_interrupt_ctrl with a behavioural reference model.
module tb_ps_interrupt_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        interrupt = 1'b0;
    logic        ps_idle = 1'b0;
    logic        ps_int_en = 1'b0;
    logic [15:0] ps_pc = '0;
    logic        ps_int_ack = 1'b0;
    logic        ps_rti = 1'b0;
    logic        int_req, int_wake, int_busy, int_lost;
    logic [15:0] int_vector, int_ret_addr;

    int total = 0;
    int bad = 0;

    // Reference model: request-level view of the controller.
    bit          m_prev_in;    // interrupt line as seen at the previous edge
    bit          m_queued;     // a request is waiting to be offered
    bit          m_asking;     // branch-to-vector request is being offered
    bit          m_serving;    // service routine running
    bit          m_lost;
    logic [15:0] m_ret;

    ps_interrupt_ctrl #(.PMA_SIZE(16), .INT_VECTOR(16'h0004)) dut (
        .clk          (clk),
        .reset        (reset),
        .interrupt    (interrupt),
        .ps_idle      (ps_idle),
        .ps_int_en    (ps_int_en),
        .ps_pc        (ps_pc),
        .ps_int_ack   (ps_int_ack),
        .ps_rti       (ps_rti),
        .int_req      (int_req),
        .int_vector   (int_vector),
        .int_ret_addr (int_ret_addr),
        .int_wake     (int_wake),
        .int_busy     (int_busy),
        .int_lost     (int_lost)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        m_prev_in = 0; m_queued = 0; m_asking = 0; m_serving = 0; m_lost = 0; m_ret = '0;
    endtask

    // Apply the controller's rules for one clock edge using the inputs present at that edge.
    task automatic model_edge();
        bit new_req, taken, nq;
        if (reset) begin
            model_clear();
            return;
        end
        new_req = interrupt && !m_prev_in;
        m_prev_in = interrupt;
        taken = m_asking && ps_int_ack;
        if (new_req && m_queued && !taken) m_lost = 1;
        nq = new_req ? 1'b1 : (taken ? 1'b0 : m_queued);
        if (m_serving) begin
            if (ps_rti) m_serving = 0;
        end else if (m_asking) begin
            if (ps_int_ack) begin
                m_ret = ps_pc; m_asking = 0; m_serving = 1;
            end else if (!ps_int_en) begin
                m_asking = 0;
            end
        end else if (m_queued && ps_int_en) begin
            m_asking = 1;
        end
        m_queued = nq;
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1; interrupt = 0; ps_idle = 0; ps_int_en = 0; ps_pc = '0;
        ps_int_ack = 0; ps_rti = 0;
        model_clear();
        tick(); tick();
        reset = 0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (int_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", int_req); end
        total++; if (int_wake !== 1'b0) begin bad++; $display("FAIL reset_wake got=%b exp=0", int_wake); end
        total++; if (int_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", int_busy); end
        total++; if (int_lost !== 1'b0) begin bad++; $display("FAIL reset_lost got=%b exp=0", int_lost); end
        total++; if (int_ret_addr !== 16'h0000) begin bad++; $display("FAIL reset_ret got=%h exp=0000", int_ret_addr); end
        total++; if (int_vector !== 16'h0004) begin bad++; $display("FAIL vector got=%h exp=0004", int_vector); end
    endtask

    task automatic test_basic();
        do_reset();
        ps_idle = 1; ps_int_en = 1; interrupt = 1;
        tick();                       // E0: request latched
        interrupt = 0;
        total++; if (int_req !== 1'b0) begin bad++; $display("FAIL basic_req_e0 got=%b exp=0", int_req); end
        tick();                       // E1: request offered
        total++; if (int_req !== 1'b1) begin bad++; $display("FAIL basic_req_e1 got=%b exp=1", int_req); end
        total++; if (int_wake !== 1'b1) begin bad++; $display("FAIL basic_wake got=%b exp=1", int_wake); end
        ps_idle = 0; #1;
        total++; if (int_wake !== 1'b0) begin bad++; $display("FAIL basic_wake_comb got=%b exp=0", int_wake); end
        ps_int_ack = 1; ps_pc = 16'h0012;
        tick();
        ps_int_ack = 0; ps_pc = 16'h7777;
        total++; if (int_ret_addr !== 16'h0012) begin bad++; $display("FAIL basic_ret got=%h exp=0012", int_ret_addr); end
        total++; if (int_busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", int_busy); end
        total++; if (int_req !== 1'b0) begin bad++; $display("FAIL basic_req_svc got=%b exp=0", int_req); end
        ps_int_ack = 1;               // ack outside the request state is ignored
        tick(); tick();
        ps_int_ack = 0;
        total++; if (int_ret_addr !== 16'h0012) begin bad++; $display("FAIL basic_ret_hold got=%h exp=0012", int_ret_addr); end
        ps_rti = 1;
        tick();
        ps_rti = 0;
        total++; if (int_busy !== 1'b0) begin bad++; $display("FAIL basic_rti got=%b exp=0", int_busy); end
    endtask

    task automatic test_held_level();
        int served = 0;
        do_reset();
        ps_int_en = 1;
        for (int i = 0; i < 16; i++) begin
            interrupt = (i < 6);
            ps_int_ack = int_req;
            ps_rti = int_busy;
            if (int_req) served++;
            tick();
        end
        ps_int_ack = 0; ps_rti = 0; interrupt = 0;
        total++; if (served !== 1) begin bad++; $display("FAIL held_count got=%0d exp=1", served); end
        total++; if (int_lost !== 1'b0) begin bad++; $display("FAIL held_lost got=%b exp=0", int_lost); end
    endtask

    task automatic test_disabled();
        int seen = 0;
        do_reset();
        ps_int_en = 0; interrupt = 1;
        tick();
        interrupt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (int_req) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL dis_req got=%0d cycles exp=0", seen); end
        ps_int_en = 1;
        tick();
        total++; if (int_req !== 1'b1) begin bad++; $display("FAIL dis_enable got=%b exp=1", int_req); end
        ps_int_en = 0;                // withdraw while offered: request stays pending
        tick();
        total++; if (int_req !== 1'b0) begin bad++; $display("FAIL dis_withdraw got=%b exp=0", int_req); end
        ps_int_en = 1;
        tick();
        total++; if (int_req !== 1'b1) begin bad++; $display("FAIL dis_retained got=%b exp=1", int_req); end
    endtask

    task automatic test_service_pulse();
        do_reset();
        ps_int_en = 1; interrupt = 1;
        tick(); interrupt = 0;
        tick(); ps_int_ack = 1; ps_pc = 16'h0100;
        tick(); ps_int_ack = 0;
        interrupt = 1;                // new request while servicing
        tick(); interrupt = 0;
        tick();
        total++; if (int_req !== 1'b0 || int_busy !== 1'b1) begin bad++; $display("FAIL svc_nonest got req=%b busy=%b exp req=0 busy=1", int_req, int_busy); end
        ps_rti = 1;
        tick(); ps_rti = 0;
        total++; if (int_busy !== 1'b0 || int_req !== 1'b0) begin bad++; $display("FAIL svc_rti got req=%b busy=%b exp 0 0", int_req, int_busy); end
        tick();
        total++; if (int_req !== 1'b1) begin bad++; $display("FAIL svc_next_req got=%b exp=1", int_req); end
        ps_rti = 1;                   // rti outside service is ignored
        tick(); ps_rti = 0;
        total++; if (int_req !== 1'b1) begin bad++; $display("FAIL svc_rti_ign got=%b exp=1", int_req); end
        interrupt = 1;                // second request before ack
        tick(); interrupt = 0;
        total++; if (int_lost !== 1'b1) begin bad++; $display("FAIL svc_lost got=%b exp=1", int_lost); end
        ps_int_ack = 1; ps_pc = 16'h0200;
        tick(); ps_int_ack = 0;
        total++; if (int_ret_addr !== 16'h0200 || int_lost !== 1'b1) begin bad++; $display("FAIL svc_lost_sticky got ret=%h lost=%b exp 0200 1", int_ret_addr, int_lost); end
    endtask

    task automatic test_ack_rise();
        do_reset();
        ps_int_en = 1; interrupt = 1;
        tick(); interrupt = 0;
        tick();
        ps_int_ack = 1; interrupt = 1; ps_pc = 16'h0033;
        tick();
        ps_int_ack = 0; interrupt = 0;
        total++; if (int_busy !== 1'b1 || int_lost !== 1'b0) begin bad++; $display("FAIL ackrise got busy=%b lost=%b exp 1 0", int_busy, int_lost); end
        ps_rti = 1;
        tick(); ps_rti = 0;
        tick();
        total++; if (int_req !== 1'b1) begin bad++; $display("FAIL ackrise_pending got=%b exp=1", int_req); end
    endtask

    task automatic test_reset_mid_service();
        int seen = 0;
        do_reset();
        ps_int_en = 1; interrupt = 1;
        tick(); interrupt = 0;
        tick(); ps_int_ack = 1; ps_pc = 16'h0044;
        tick(); ps_int_ack = 0;
        interrupt = 1;                // leave a request pending behind the service
        tick(); interrupt = 0;
        #2;
        reset = 1; model_clear();
        #1;
        total++; if (int_busy !== 1'b0) begin bad++; $display("FAIL rst_async_busy got=%b exp=0", int_busy); end
        total++; if (int_ret_addr !== 16'h0000) begin bad++; $display("FAIL rst_async_ret got=%h exp=0000", int_ret_addr); end
        tick(); reset = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (int_req) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rst_pending got=%0d req cycles exp=0", seen); end
    endtask

    task automatic test_random();
        do_reset();
        model_clear();
        for (int i = 0; i < 400; i++) begin
            interrupt  = ($urandom_range(0, 3) == 0);
            ps_int_en  = ($urandom_range(0, 4) != 0);
            ps_int_ack = $urandom_range(0, 1) == 1;
            ps_rti     = ($urandom_range(0, 2) == 0);
            ps_idle    = $urandom_range(0, 1) == 1;
            ps_pc      = 16'($urandom);
            tick();
            #0;
            total++; if (int_req !== m_asking) begin bad++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", i, int_req, m_asking); end
            total++; if (int_busy !== m_serving) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", i, int_busy, m_serving); end
            total++; if (int_wake !== (m_asking && ps_idle)) begin bad++; $display("FAIL rnd_wake cyc=%0d got=%b exp=%b", i, int_wake, m_asking && ps_idle); end
            total++; if (int_lost !== m_lost) begin bad++; $display("FAIL rnd_lost cyc=%0d got=%b exp=%b", i, int_lost, m_lost); end
            total++; if (int_ret_addr !== m_ret) begin bad++; $display("FAIL rnd_ret cyc=%0d got=%h exp=%h", i, int_ret_addr, m_ret); end
            if (($urandom_range(0, 60) == 0)) begin
                reset = 1;
                tick();
                reset = 0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_held_level();
        test_disabled();
        test_service_pulse();
        test_ack_rise();
        test_reset_mid_service();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ps_interrupt_ctrl
